// File: rtl/tone_sequencer.sv
// Melody scheduler: walks a fixed 16-step scale, offers each pitch code to the
// NCO config stage over valid/ready, then gates the tone for the note duration.
module tone_sequencer #(
  parameter int unsigned TICKS_PER_BEAT = 6_250_000,
  parameter int unsigned GAP_TICKS      = 625_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       loop,
  input  logic       cfg_ready,
  output logic       cfg_valid,
  output logic [3:0] cfg_code,
  output logic       tone_on,
  output logic       playing,
  output logic       melody_end,
  output logic [3:0] note_index
);

  localparam int unsigned CW = $clog2(2 * TICKS_PER_BEAT);

  localparam logic [CW-1:0] TONE1_LAST = CW'(TICKS_PER_BEAT - GAP_TICKS - 1);
  localparam logic [CW-1:0] TONE2_LAST = CW'(2 * TICKS_PER_BEAT - GAP_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TONE,
    S_GAP,
    S_END
  } state_t;

  state_t        state;
  logic          enable_q;
  logic [CW-1:0] counter;
  logic [CW-1:0] tone_last;
  logic          tone_done;
  logic          step_done;
  logic          last_step;
  logic [3:0]    next_index;

  // Ascending C4..C5 over steps 0..7, then descending back to C4.
  function automatic logic [3:0] step_code(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd4;
      4'd4:    code = 4'd5;
      4'd5:    code = 4'd6;
      4'd6:    code = 4'd7;
      4'd7:    code = 4'd8;
      4'd8:    code = 4'd8;
      4'd9:    code = 4'd7;
      4'd10:   code = 4'd6;
      4'd11:   code = 4'd5;
      4'd12:   code = 4'd4;
      4'd13:   code = 4'd3;
      4'd14:   code = 4'd2;
      default: code = 4'd1;
    endcase
    return code;
  endfunction

  // Steps 7 and 15 are the two-beat notes at the top and bottom of the scale.
  always_comb begin
    tone_last  = (note_index[2:0] == 3'b111) ? TONE2_LAST : TONE1_LAST;
    tone_done  = (state == S_TONE) && (counter == tone_last);
    // With no gap configured, the note finishes straight out of TONE.
    step_done  = (tone_done && (GAP_TICKS == 0)) ||
                 ((state == S_GAP) && (counter == GAP_LAST));
    last_step  = (note_index == 4'd15);
    next_index = note_index + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      enable_q   <= 1'b0;
      counter    <= '0;
      cfg_valid  <= 1'b0;
      cfg_code   <= '0;
      tone_on    <= 1'b0;
      playing    <= 1'b0;
      melody_end <= 1'b0;
      note_index <= '0;
    end else begin
      enable_q <= enable;
      // Abort wins over every other transition, END included.
      if ((state != S_IDLE) && !enable) begin
        state      <= S_IDLE;
        counter    <= '0;
        cfg_valid  <= 1'b0;
        cfg_code   <= '0;
        tone_on    <= 1'b0;
        playing    <= 1'b0;
        melody_end <= 1'b0;
        note_index <= '0;
      end else if (step_done) begin
        tone_on <= 1'b0;
        counter <= '0;
        if (last_step) begin
          state      <= S_END;
          melody_end <= 1'b1;
        end else begin
          state      <= S_LOAD;
          note_index <= next_index;
          cfg_valid  <= 1'b1;
          cfg_code   <= step_code(next_index);
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (enable && !enable_q) begin
              state      <= S_LOAD;
              note_index <= '0;
              cfg_valid  <= 1'b1;
              cfg_code   <= step_code(4'd0);
              playing    <= 1'b1;
            end
          end
          S_LOAD: begin
            if (cfg_ready) begin
              state     <= S_TONE;
              cfg_valid <= 1'b0;
              tone_on   <= 1'b1;
              counter   <= '0;
            end
          end
          S_TONE: begin
            if (tone_done) begin
              state   <= S_GAP;
              tone_on <= 1'b0;
              counter <= '0;
            end else begin
              counter <= counter + CW'(1);
            end
          end
          S_GAP: begin
            counter <= counter + CW'(1);
          end
          S_END: begin
            melody_end <= 1'b0;
            note_index <= '0;
            if (loop) begin
              state     <= S_LOAD;
              cfg_valid <= 1'b1;
              cfg_code  <= step_code(4'd0);
            end else begin
              state   <= S_IDLE;
              playing <= 1'b0;
            end
          end
          default: begin
            state     <= S_IDLE;
            playing   <= 1'b0;
            cfg_valid <= 1'b0;
            tone_on   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with TICKS_PER_BEAT=10, GAP_TICKS=2.
module tb_tone_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       loop;
  logic       cfg_ready;
  logic       cfg_valid;
  logic [3:0] cfg_code;
  logic       tone_on;
  logic       playing;
  logic       melody_end;
  logic [3:0] note_index;

  int errors = 0;
  int checks = 0;

  tone_sequencer #(
    .TICKS_PER_BEAT(10),
    .GAP_TICKS     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .loop      (loop),
    .cfg_ready (cfg_ready),
    .cfg_valid (cfg_valid),
    .cfg_code  (cfg_code),
    .tone_on   (tone_on),
    .playing   (playing),
    .melody_end(melody_end),
    .note_index(note_index)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Force IDLE via abort, then raise enable; returns in LOAD of step 0.
  task automatic restart();
    enable = 1'b0;
    adv(2);
    enable = 1'b1;
    adv(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; loop = 1'b0; cfg_ready = 1'b1;
    adv(3);
    checks++;
    if ({cfg_valid, cfg_code, tone_on, playing, melody_end, note_index} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b code=%0d tone=%b play=%b end=%b idx=%0d, want all 0",
               cfg_valid, cfg_code, tone_on, playing, melody_end, note_index);
    end
    rst = 1'b0;
    adv(2);
    checks++;
    if (playing !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_enable: playing=%b want 0", playing);
    end
  endtask

  task automatic test_start();
    logic want;
    enable = 1'b1;
    adv(1);
    checks++;
    if (cfg_valid !== 1'b1 || cfg_code !== 4'd1 || note_index !== 4'd0 || playing !== 1'b1 || tone_on !== 1'b0) begin
      errors++;
      $display("FAIL start_load: v=%b code=%0d idx=%0d play=%b tone=%b want v=1 code=1 idx=0 play=1 tone=0",
               cfg_valid, cfg_code, note_index, playing, tone_on);
    end
    for (int i = 0; i < 10; i++) begin
      adv(1);
      want = (i < 8);
      checks++;
      if (tone_on !== want) begin
        errors++;
        $display("FAIL start_tone_cycle%0d: tone_on=%b want %b", i + 2, tone_on, want);
      end
    end
    adv(1);
    checks++;
    if (cfg_valid !== 1'b1 || cfg_code !== 4'd2 || note_index !== 4'd1) begin
      errors++;
      $display("FAIL step1_load: v=%b code=%0d idx=%0d want v=1 code=2 idx=1",
               cfg_valid, cfg_code, note_index);
    end
  endtask

  task automatic test_full_melody();
    int codes[$];
    int runs[$];
    int run;
    int end_t;
    int ends;
    int want;
    loop = 1'b0;
    restart();
    run = 0; end_t = -1; ends = 0;
    for (int t = 0; t < 260; t++) begin
      if (t > 0) adv(1);
      if (cfg_valid) codes.push_back(int'(cfg_code));
      if (tone_on) run++;
      else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
      if (melody_end) begin
        ends++;
        if (end_t < 0) end_t = t;
      end
    end
    checks++;
    if (codes.size() != 16 || runs.size() != 16) begin
      errors++;
      $display("FAIL full_counts: codes=%0d runs=%0d want 16 16", codes.size(), runs.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        want = (i < 8) ? i + 1 : 16 - i;
        checks++;
        if (codes[i] != want) begin
          errors++;
          $display("FAIL full_code_step%0d: got %0d want %0d", i, codes[i], want);
        end
        want = (i == 7 || i == 15) ? 18 : 8;
        checks++;
        if (runs[i] != want) begin
          errors++;
          $display("FAIL full_tone_len_step%0d: got %0d want %0d", i, runs[i], want);
        end
      end
    end
    // 14 one-beat steps of 11 cycles plus 2 two-beat steps of 21 cycles.
    checks++;
    if (end_t != 196 || ends != 1) begin
      errors++;
      $display("FAIL full_melody_end: at %0d count %0d want at 196 count 1", end_t, ends);
    end
    checks++;
    if (playing !== 1'b0 || cfg_valid !== 1'b0 || note_index !== 4'd0) begin
      errors++;
      $display("FAIL full_no_restart: play=%b v=%b idx=%0d want 0 0 0", playing, cfg_valid, note_index);
    end
  endtask

  task automatic test_loop();
    int k;
    bit found;
    loop = 1'b1;
    restart();
    found = 0;
    for (k = 1; k <= 300; k++) begin
      adv(1);
      if (melody_end) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found || k != 196) begin
      errors++;
      $display("FAIL loop_first_end: found=%0d at %0d want found at 196", found, k);
    end
    adv(1);
    checks++;
    if (cfg_valid !== 1'b1 || cfg_code !== 4'd1 || note_index !== 4'd0 || playing !== 1'b1 || melody_end !== 1'b0) begin
      errors++;
      $display("FAIL loop_wrap: v=%b code=%0d idx=%0d play=%b end=%b want 1 1 0 1 0",
               cfg_valid, cfg_code, note_index, playing, melody_end);
    end
    found = 0;
    for (k = 1; k <= 300; k++) begin
      adv(1);
      if (k == 50) loop = 1'b0;
      if (melody_end) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found || k != 196) begin
      errors++;
      $display("FAIL loop_second_end: found=%0d at %0d want found at 196", found, k);
    end
    adv(2);
    checks++;
    if (playing !== 1'b0 || cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop: play=%b v=%b want 0 0", playing, cfg_valid);
    end
  endtask

  task automatic test_backpressure();
    loop = 1'b0;
    cfg_ready = 1'b1;
    restart();
    adv(33);
    checks++;
    if (cfg_valid !== 1'b1 || cfg_code !== 4'd4 || note_index !== 4'd3) begin
      errors++;
      $display("FAIL bp_load_step3: v=%b code=%0d idx=%0d want 1 4 3", cfg_valid, cfg_code, note_index);
    end
    cfg_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      adv(1);
      checks++;
      if (cfg_valid !== 1'b1 || cfg_code !== 4'd4 || tone_on !== 1'b0 || playing !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall%0d: v=%b code=%0d tone=%b play=%b want 1 4 0 1",
                 i, cfg_valid, cfg_code, tone_on, playing);
      end
    end
    cfg_ready = 1'b1;
    adv(1);
    checks++;
    if (tone_on !== 1'b1 || cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_tone_start: tone=%b v=%b want 1 0", tone_on, cfg_valid);
    end
    // Step 3 began at LOAD offset 0; the next LOAD lands 16 cycles later.
    adv(9);
    checks++;
    if (cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_period_early: v=%b want 0 at offset 15", cfg_valid);
    end
    adv(1);
    checks++;
    if (cfg_valid !== 1'b1 || cfg_code !== 4'd5 || note_index !== 4'd4) begin
      errors++;
      $display("FAIL bp_period: v=%b code=%0d idx=%0d want 1 5 4 at offset 16", cfg_valid, cfg_code, note_index);
    end
  endtask

  task automatic test_abort();
    int seen_end;
    loop = 1'b0;
    restart();
    adv(58);
    checks++;
    if (tone_on !== 1'b1 || note_index !== 4'd5) begin
      errors++;
      $display("FAIL abort_pre: tone=%b idx=%0d want 1 5", tone_on, note_index);
    end
    enable = 1'b0;
    adv(1);
    checks++;
    if (tone_on !== 1'b0 || note_index !== 4'd0 || playing !== 1'b0 || cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: tone=%b idx=%0d play=%b v=%b want 0 0 0 0",
               tone_on, note_index, playing, cfg_valid);
    end
    seen_end = 0;
    for (int i = 0; i < 4; i++) begin
      if (melody_end) seen_end++;
      adv(1);
    end
    checks++;
    if (seen_end != 0) begin
      errors++;
      $display("FAIL abort_no_end: melody_end seen %0d want 0", seen_end);
    end
    enable = 1'b1;
    adv(1);
    checks++;
    if (cfg_valid !== 1'b1 || cfg_code !== 4'd1 || note_index !== 4'd0) begin
      errors++;
      $display("FAIL abort_restart: v=%b code=%0d idx=%0d want 1 1 0", cfg_valid, cfg_code, note_index);
    end
  endtask

  task automatic test_reset_mid_gap();
    restart();
    adv(10);
    checks++;
    if (tone_on !== 1'b0 || playing !== 1'b1 || cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL rgap_in_gap: tone=%b play=%b v=%b want 0 1 0", tone_on, playing, cfg_valid);
    end
    rst = 1'b1;
    adv(1);
    checks++;
    if ({cfg_valid, cfg_code, tone_on, playing, melody_end, note_index} !== 12'h000) begin
      errors++;
      $display("FAIL rgap_reset: v=%b code=%0d tone=%b play=%b end=%b idx=%0d want all 0",
               cfg_valid, cfg_code, tone_on, playing, melody_end, note_index);
    end
    rst = 1'b0;
    adv(1);
    checks++;
    if (cfg_valid !== 1'b1 || cfg_code !== 4'd1 || note_index !== 4'd0 || playing !== 1'b1) begin
      errors++;
      $display("FAIL rgap_restart: v=%b code=%0d idx=%0d play=%b want 1 1 0 1",
               cfg_valid, cfg_code, note_index, playing);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_full_melody();
    test_loop();
    test_backpressure();
    test_abort();
    test_reset_mid_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
